inject_campaign_ctrl: RTL and testbench
=======================================

// Module: inject_campaign_ctrl
// PURPOSE
//  Sequences an exhaustive single-bit fault-injection campaign over the golden/injected DUT pair testbench.
//  For each target bit 0..TOTAL_BITS-1 it does three things: resets both designs, runs them, then flips that one bit at a fixed cycle.
//  Drives run_designs, cycle_number and verinject__injector_state into the testbench.
//  Captures the first mismatch log word of each run into a record FIFO for the host.
// PARAMETERS
//  TOTAL_BITS  24584  number of injectable state bits; campaign covers 0..TOTAL_BITS-1
//  RST_CYCLES  4      cycles run_designs held low before each run (>=1)
//  RUN_CYCLES  256    cycles per run with run_designs high (>=2)
//  INJ_CYCLE   16     cycle_number at which the bit flip is applied (< RUN_CYCLES)
//  LOG_DEPTH   16     record FIFO depth, power of two (>=2)
// PORTS
//  clock                      in   1   single clock, all logic rising-edge
//  reset                      in   1   asynchronous, active-high
//  start                      in   1   pulse; begins campaign from bit 0 (honoured in IDLE or DONE)
//  abort                      in   1   pulse; stops campaign, returns to IDLE
//  busy                       out  1   high in RESET/RUN/NEXT
//  done                       out  1   high in DONE
//  run_designs                out  1   testbench run / active-low DUT reset
//  cycle_number               out  48  cycles since run_designs rose in current run
//  verinject__injector_state  out  32  bit index to flip this cycle; 32'hFFFF_FFFF = no injection
//  log_write                  in   1   testbench mismatch strobe
//  log_data                   in   64  testbench mismatch word {cycle[31:0], xor_sum}
//  rec_valid                  out  1   FIFO not empty
//  rec_ready                  in   1   host pop; pop occurs when rec_valid && rec_ready
//  rec_data                   out  96  head record {bit_index[31:0], log_data[63:0]}
//  overflow_count             out  16  dropped records, saturates at 16'hFFFF
//  runs_done                  out  32  completed runs in current campaign
// BEHAVIOUR
//  Reset values: all outputs 0, except verinject__injector_state = 32'hFFFF_FFFF.
//  Reset also empties the FIFO; reset mid-campaign aborts it with no partial state kept.
//  All outputs are registered; rec_data is the FIFO head, valid in the same cycle as rec_valid.
//  FSM IDLE -> RESET -> RUN -> NEXT -> (RESET | DONE):
//   IDLE: run_designs=0, cycle_number=0.
//     On start: bit_idx<=0, runs_done<=0, rcnt<=0, go to RESET.
//   RESET: run_designs=0 for exactly RST_CYCLES cycles, then RUN.
//   RUN: run_designs=1; cycle_number=0 on the first RUN cycle, +1 each cycle.
//     logged flag cleared on entry.
//     After the cycle with cycle_number==RUN_CYCLES-1, go to NEXT.
//   NEXT: 1 cycle, run_designs=0, cycle_number<=0, runs_done+1.
//     If bit_idx==TOTAL_BITS-1, go to DONE; else bit_idx+1 and go to RESET.
//   DONE: outputs idle as IDLE.
//     start restarts from bit 0; FIFO and overflow_count are kept.
//  Per-bit period is RST_CYCLES+RUN_CYCLES+1 cycles.
//  Injection: verinject__injector_state=bit_idx only in the RUN cycle where cycle_number==INJ_CYCLE.
//    It is driven in the same cycle as that cycle_number value; 32'hFFFF_FFFF at all other times.
//  Capture: in RUN only, log_write && !logged pushes {bit_idx, log_data} and sets logged.
//    Later strobes in the same run are ignored.
//    log_write outside RUN is ignored.
//  FIFO full: a push is accepted if not full, or if a pop occurs in the same cycle.
//    Otherwise it is dropped and overflow_count increments, saturating.
//    A dropped push still sets logged.
//  Empty: rec_ready while !rec_valid has no effect.
//  Abort: in any state, the next cycle is IDLE with idle outputs.
//    The FIFO is kept; runs_done keeps its value.
//    abort wins over simultaneous start.
//  start while busy: ignored.
//  Counters: cycle_number 48-bit, no wrap in range; bit_idx 32-bit; runs_done 32-bit.
// TESTING (TOTAL_BITS=4, RST_CYCLES=2, RUN_CYCLES=8, INJ_CYCLE=3, LOG_DEPTH=2)
//  1. Clean campaign: start, no log_write.
//     -> 4 runs of 11 cycles; injector_state = 0,1,2,3, each single cycle, at cycle_number=3.
//     -> done 44 cycles after the start edge; runs_done=4; rec_valid stays 0.
//  2. Capture: log_write during run of bit 1 at cycle_number 5 (data 64'h5_0000_0010) and at 6.
//     -> exactly one record {32'd1, 64'h5_0000_0010}.
//  3. Overflow: log_write in every run, rec_ready=0.
//     -> 2 records (bits 0,1); overflow_count=2.
//  4. Full with simultaneous pop: rec_ready=1 in the push cycle while full.
//     -> push accepted; count stays 2; overflow unchanged.
//  5. Abort in RUN at cycle_number 4 of bit 2.
//     -> next cycle: IDLE, run_designs=0, injector_state=FFFF_FFFF.
//     -> a new start begins at bit 0; runs_done restarts at 0.
//  6. Async reset asserted mid-RUN between edges.
//     -> outputs go to reset values immediately; FIFO empty; IDLE after release.

Source files
------------

// File: rtl/inject_campaign_ctrl.sv
// Drives an exhaustive single-bit fault-injection campaign over a golden/injected DUT pair.
// It captures the first mismatch word of each run into a small record FIFO for the host.
module inject_campaign_ctrl #(
  parameter int TOTAL_BITS = 24584,
  parameter int RST_CYCLES = 4,
  parameter int RUN_CYCLES = 256,
  parameter int INJ_CYCLE  = 16,
  parameter int LOG_DEPTH  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        run_designs,
  output logic [47:0] cycle_number,
  output logic [31:0] verinject__injector_state,
  input  logic        log_write,
  input  logic [63:0] log_data,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [95:0] rec_data,
  output logic [15:0] overflow_count,
  output logic [31:0] runs_done
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam logic [31:0] NO_INJ = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // state is kept as a named signal so checkers can bind to it hierarchically
  state_t      state;
  logic [31:0] bit_idx;
  logic [15:0] rcnt;
  logic        logged;

  logic [95:0] mem [LOG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          accept;

  assign push_req = (state == RUN) && log_write && !logged;
  assign pop      = rec_valid && rec_ready;
  assign full     = (count == (AW+1)'(LOG_DEPTH));
  // A pop in the same cycle frees the slot the push is about to take
  assign accept   = push_req && (!full || pop);
  assign rec_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (accept && !pop) count_next = count + 1'b1;
    else if (!accept && pop) count_next = count - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                     <= IDLE;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      run_designs               <= 1'b0;
      cycle_number              <= '0;
      verinject__injector_state <= NO_INJ;
      bit_idx                   <= '0;
      runs_done                 <= '0;
      rcnt                      <= '0;
      logged                    <= 1'b0;
    end else begin
      if (push_req) logged <= 1'b1;
      if (abort) begin
        state                     <= IDLE;
        busy                      <= 1'b0;
        done                      <= 1'b0;
        run_designs               <= 1'b0;
        cycle_number              <= '0;
        verinject__injector_state <= NO_INJ;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              bit_idx   <= '0;
              runs_done <= '0;
              rcnt      <= '0;
              state     <= RESET;
              busy      <= 1'b1;
              done      <= 1'b0;
            end
          end
          RESET: begin
            if (rcnt == 16'(RST_CYCLES - 1)) begin
              state        <= RUN;
              run_designs  <= 1'b1;
              cycle_number <= '0;
              logged       <= 1'b0;
              verinject__injector_state <= (INJ_CYCLE == 0) ? bit_idx : NO_INJ;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          RUN: begin
            if (cycle_number == 48'(RUN_CYCLES - 1)) begin
              state                     <= NEXT;
              run_designs               <= 1'b0;
              cycle_number              <= '0;
              verinject__injector_state <= NO_INJ;
            end else begin
              cycle_number <= cycle_number + 1'b1;
              // Register the flip so it appears alongside the matching cycle_number
              verinject__injector_state <=
                (cycle_number + 1'b1 == 48'(INJ_CYCLE)) ? bit_idx : NO_INJ;
            end
          end
          NEXT: begin
            runs_done <= runs_done + 1'b1;
            if (bit_idx == 32'(TOTAL_BITS - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              rcnt    <= '0;
              state   <= RESET;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rec_valid      <= 1'b0;
      overflow_count <= '0;
      for (int i = 0; i < LOG_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {bit_idx, log_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !accept && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 1'b1;
      count     <= count_next;
      rec_valid <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_inject_campaign_ctrl.sv
// Bench for inject_campaign_ctrl: directed campaign scenarios followed by random traffic,
// scored against a model that derives each cycle's outputs from the position within the campaign.
module tb_inject_campaign_ctrl;

  localparam int TB  = 4;
  localparam int RC  = 2;
  localparam int RN  = 8;
  localparam int IC  = 3;
  localparam int D   = 2;
  localparam int PER = RC + RN + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, log_write, rec_ready;
  logic [63:0] log_data;
  logic        busy, done, run_designs, rec_valid;
  logic [47:0] cycle_number;
  logic [31:0] inj_state, runs_done;
  logic [95:0] rec_data;
  logic [15:0] overflow_count;

  int total = 0;
  int bad   = 0;

  // model state
  int m_active, m_t, m_done, m_runs, m_logged_run, m_ovf;
  logic [95:0] exp_q[$];
  int mv_run, mv_cn, mv_b, mv_off;

  inject_campaign_ctrl #(
    .TOTAL_BITS(TB), .RST_CYCLES(RC), .RUN_CYCLES(RN), .INJ_CYCLE(IC), .LOG_DEPTH(D)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .run_designs(run_designs), .cycle_number(cycle_number),
    .verinject__injector_state(inj_state), .log_write(log_write), .log_data(log_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .overflow_count(overflow_count), .runs_done(runs_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_t = 0; m_done = 0; m_runs = 0; m_logged_run = -1; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_view();
    mv_off = m_t % PER;
    mv_b   = m_t / PER;
    mv_run = (m_active != 0) && mv_off >= RC && mv_off < RC + RN;
    mv_cn  = mv_run ? mv_off - RC : 0;
  endtask

  task automatic compare_all();
    logic [31:0] exp_inj;
    exp_inj = (mv_run && mv_cn == IC) ? 32'(mv_b) : 32'hFFFF_FFFF;
    check("busy", 96'(busy), 96'(m_active != 0));
    check("done", 96'(done), 96'(m_done != 0));
    check("run_designs", 96'(run_designs), 96'(mv_run));
    check("cycle_number", 96'(cycle_number), 96'(mv_cn));
    check("injector_state", 96'(inj_state), 96'(exp_inj));
    check("runs_done", 96'(runs_done), 96'(m_runs));
    check("overflow_count", 96'(overflow_count), 96'(m_ovf));
    check("rec_valid", 96'(rec_valid), 96'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("rec_data", rec_data, exp_q[0]);
  endtask

  // Wait for the next sampling point, then score the outputs of that cycle
  task automatic tick();
    @(negedge clk);
    model_view();
    compare_all();
  endtask

  // Apply inputs for the cycle just scored and step the model across the coming edge
  task automatic drive(input logic st, input logic ab, input logic lw,
                       input logic [63:0] ld, input logic rr);
    bit pop, cap, acc;
    start = st; abort = ab; log_write = lw; log_data = ld; rec_ready = rr;
    pop = rr && exp_q.size() > 0;
    cap = 0;
    if (mv_run && lw && m_logged_run != mv_b) begin
      m_logged_run = mv_b;
      cap = 1;
    end
    acc = (exp_q.size() < D) || pop;
    if (pop) void'(exp_q.pop_front());
    if (cap) begin
      if (acc) exp_q.push_back({32'(mv_b), ld});
      else if (m_ovf < 65535) m_ovf++;
    end
    if (ab) begin
      m_active = 0; m_done = 0;
    end else if (!m_active && st) begin
      m_active = 1; m_t = 0; m_runs = 0; m_logged_run = -1; m_done = 0;
    end else if (m_active) begin
      if (mv_off == PER - 1) m_runs++;
      m_t++;
      if (m_t == TB * PER) begin
        m_active = 0; m_done = 1;
      end
    end
  endtask

  task automatic idle_cycles(input int n, input logic rr);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0, 64'd0, rr);
    end
  endtask

  initial begin
    reset = 1'b1; start = 0; abort = 0; log_write = 0; log_data = '0; rec_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2, 1'b0);

    // Clean campaign
    tick(); drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    idle_cycles(TB * PER + 3, 1'b0);
    check("clean_done", 96'(done), 96'd1);
    check("clean_runs", 96'(runs_done), 96'd4);

    // Single capture per run, later strobe ignored
    tick(); drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < TB * PER + 3; i++) begin
      tick();
      if (mv_run && mv_b == 1 && mv_cn == 5) drive(1'b0, 1'b0, 1'b1, 64'h5_0000_0010, 1'b0);
      else if (mv_run && mv_b == 1 && mv_cn == 6)
        drive(1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
      else drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    end
    check("capture_rec", rec_data, {32'd1, 64'h5_0000_0010});
    idle_cycles(3, 1'b1);
    check("capture_drained", 96'(rec_valid), 96'd0);

    // Overflow with host stalled
    tick(); drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < TB * PER + 3; i++) begin
      tick();
      drive(1'b0, 1'b0, 1'(mv_run), {$urandom, $urandom}, 1'b0);
    end
    check("overflow_cnt", 96'(overflow_count), 96'd2);
    check("overflow_head", 96'(rec_data[95:64]), 96'd0);

    // Push while full with a pop in the same cycle
    tick(); drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < TB * PER + 3; i++) begin
      tick();
      if (mv_run && mv_b == 0 && mv_cn == 0)
        drive(1'b0, 1'b0, 1'b1, 64'hABCD_0000_1234_5678, 1'b1);
      else drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    end
    check("full_pop_ovf", 96'(overflow_count), 96'd2);
    check("full_pop_valid", 96'(rec_valid), 96'd1);
    idle_cycles(3, 1'b1);

    // Abort in RUN at bit 2, cycle 4, then restart from bit 0
    tick(); drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < TB * PER + 3; i++) begin
      tick();
      if (mv_run && mv_b == 2 && mv_cn == 4) begin
        drive(1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
        break;
      end
      drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    check("abort_runs", 96'(runs_done), 96'd2);
    check("abort_idle_inj", 96'(inj_state), 96'hFFFF_FFFF);
    tick(); drive(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    tick(); drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    idle_cycles(PER + 2, 1'b0);

    // Asynchronous reset between edges while running
    for (int i = 0; i < 3 * PER; i++) begin
      tick();
      drive(1'b0, 1'b0, 1'(mv_run), {$urandom, $urandom}, 1'b0);
      if (mv_run) break;
    end
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_run", 96'(run_designs), 96'd0);
    check("rst_cycle", 96'(cycle_number), 96'd0);
    check("rst_inj", 96'(inj_state), 96'hFFFF_FFFF);
    check("rst_valid", 96'(rec_valid), 96'd0);
    check("rst_data", rec_data, 96'd0);
    check("rst_ovf", 96'(overflow_count), 96'd0);
    check("rst_runs", 96'(runs_done), 96'd0);
    start = 0; abort = 0; log_write = 0; rec_ready = 0;
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    idle_cycles(2, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 299) == 0),
            1'($urandom_range(0, 5) == 0), {$urandom, $urandom},
            1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
